// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the 8-bit computer's PC/fetch sequencer.
package pc_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned OFF_W_DEF  = 3;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    SEQ,
    BR,
    JAL,
    JR
  } pc_sel_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: jr > jal > branch > sequential, all modulo 2^ADDR_W.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OFF_W  = OFF_W_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              ctl_jal,
  input  logic              ctl_jr,
  input  logic              ctl_branch,
  input  logic [ADDR_W-1:0] ctl_target,
  input  logic [OFF_W-1:0]  ctl_offset,
  input  logic [ADDR_W-1:0] ra_read_data,
  output pc_sel_t           sel,
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] off_ext;

  always_comb begin
    pc_inc  = pc + ADDR_W'(1);
    off_ext = ADDR_W'($signed(ctl_offset));

    sel = SEQ;
    if (ctl_jr)          sel = JR;
    else if (ctl_jal)    sel = JAL;
    else if (ctl_branch) sel = BR;

    next_pc = pc_inc;
    case (sel)
      BR:      next_pc = pc_inc + off_ext;
      JAL:     next_pc = ctl_target;
      JR:      next_pc = ra_read_data;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and two-phase fetch/execute sequencer; feeds and reads $ra3.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OFF_W  = OFF_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  output logic              issue,
  input  logic              ctl_valid,
  input  logic              ctl_jal,
  input  logic              ctl_jr,
  input  logic              ctl_branch,
  input  logic              ctl_halt,
  input  logic [ADDR_W-1:0] ctl_target,
  input  logic [OFF_W-1:0]  ctl_offset,
  input  logic [ADDR_W-1:0] ra_read_data,
  output logic [ADDR_W-1:0] ra_write_data,
  output logic              jal_out,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  seq_state_t        state, state_n;
  pc_sel_t           sel;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              retire;
  logic              take_jal;

  pc_next_calc #(
    .ADDR_W(ADDR_W),
    .OFF_W (OFF_W)
  ) u_next (
    .pc          (pc),
    .ctl_jal     (ctl_jal),
    .ctl_jr      (ctl_jr),
    .ctl_branch  (ctl_branch),
    .ctl_target  (ctl_target),
    .ctl_offset  (ctl_offset),
    .ra_read_data(ra_read_data),
    .sel         (sel),
    .pc_inc      (pc_inc),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fetch_req = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) state_n = EXEC;
      end
      EXEC: begin
        if (ctl_valid) begin
          retire  = 1'b1;
          state_n = ctl_halt ? HALT : FETCH;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // Halt outranks every jump, so a halting jal never strobes $ra3.
  assign take_jal   = retire && !ctl_halt && (sel == JAL);
  assign fetch_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= '0;
      retired       <= '0;
      halted        <= 1'b0;
      issue         <= 1'b0;
      jal_out       <= 1'b0;
      ra_write_data <= '0;
    end else begin
      issue   <= (state == FETCH) && fetch_ack;
      jal_out <= take_jal;
      if (take_jal) ra_write_data <= pc_inc;
      if (retire) begin
        if (ctl_halt) halted <= 1'b1;
        else          pc     <= next_pc;
        if (retired != '1) retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer against an arithmetic PC model.
module tb_pc_sequencer;

  localparam int ADDR_W = 3;
  localparam int OFF_W  = 3;
  localparam int CNT_W  = 8;

  localparam int K_SEQ    = 0;
  localparam int K_BR     = 1;
  localparam int K_JAL    = 2;
  localparam int K_JR     = 3;
  localparam int K_JALJR  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic              issue;
  logic              ctl_valid, ctl_jal, ctl_jr, ctl_branch, ctl_halt;
  logic [ADDR_W-1:0] ctl_target;
  logic [OFF_W-1:0]  ctl_offset;
  logic [ADDR_W-1:0] ra_read_data;
  logic [ADDR_W-1:0] ra_write_data;
  logic              jal_out;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  int errors = 0;
  int checks = 0;
  int fetch_q[$];
  int issue_q[$];
  int jal_q[$];
  int m_pc;
  int m_ret;

  pc_sequencer #(
    .ADDR_W(ADDR_W),
    .OFF_W (OFF_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .issue        (issue),
    .ctl_valid    (ctl_valid),
    .ctl_jal      (ctl_jal),
    .ctl_jr       (ctl_jr),
    .ctl_branch   (ctl_branch),
    .ctl_halt     (ctl_halt),
    .ctl_target   (ctl_target),
    .ctl_offset   (ctl_offset),
    .ra_read_data (ra_read_data),
    .ra_write_data(ra_write_data),
    .jal_out      (jal_out),
    .pc           (pc),
    .halted       (halted),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a fetch, issue or $ra3 write.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (fetch_req && fetch_ack) begin
        if (fetch_q.size() == 0) unexpected("fetch_handshake");
        else check("fetch_addr", fetch_addr, fetch_q.pop_front());
      end
      if (issue) begin
        if (issue_q.size() == 0) unexpected("issue_pulse");
        else check("retired_at_issue", retired, issue_q.pop_front());
      end
      if (jal_out) begin
        if (jal_q.size() == 0) unexpected("jal_out_pulse");
        else check("ra_write_data", ra_write_data, jal_q.pop_front());
      end
    end
  end

  function automatic int model_next(int cur, int kind, int tgt, int off, int ra);
    int soff;
    soff = (off >= 4) ? off - 8 : off;
    case (kind)
      K_BR:    return (((cur + 1 + soff) % 8) + 8) % 8;
      K_JAL:   return tgt;
      K_JR,
      K_JALJR: return ra;
      default: return (cur + 1) % 8;
    endcase
  endfunction

  task automatic clear_ctl();
    ctl_valid  = 1'b0;
    ctl_jal    = 1'b0;
    ctl_jr     = 1'b0;
    ctl_branch = 1'b0;
    ctl_halt   = 1'b0;
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_ret = 0;
    fetch_q.delete();
    issue_q.delete();
    jal_q.delete();
  endtask

  // Entered just after a rising edge with the DUT in FETCH.
  task automatic fetch_phase(input int ack_delay, input int val_delay);
    repeat (ack_delay) begin
      ctl_valid  = 1'($urandom);
      ctl_jal    = 1'($urandom);
      ctl_jr     = 1'($urandom);
      ctl_branch = 1'($urandom);
      ctl_halt   = 1'($urandom);
      @(posedge clk); #1;
    end
    clear_ctl();
    fetch_q.push_back(m_pc);
    issue_q.push_back(m_ret);
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    repeat (val_delay) begin
      fetch_ack = 1'($urandom);
      @(posedge clk); #1;
    end
    fetch_ack = 1'b0;
  endtask

  task automatic run_instr(input int kind, input int tgt, input int off, input int ra,
                           input int ack_delay, input int val_delay);
    fetch_phase(ack_delay, val_delay);
    ctl_target   = ADDR_W'(tgt);
    ctl_offset   = OFF_W'(off);
    ra_read_data = ADDR_W'(ra);
    ctl_jal      = (kind == K_JAL) || (kind == K_JALJR);
    ctl_jr       = (kind == K_JR) || (kind == K_JALJR);
    ctl_branch   = (kind == K_BR);
    ctl_valid    = 1'b1;
    if (kind == K_JAL) jal_q.push_back((m_pc + 1) % 8);
    m_pc = model_next(m_pc, kind, tgt, off, ra);
    if (m_ret < 255) m_ret++;
    @(posedge clk); #1;
    clear_ctl();
    ra_read_data = ADDR_W'($urandom);
    check("pc_after_instr", pc, m_pc);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    fetch_ack    = 1'b0;
    ctl_target   = '0;
    ctl_offset   = '0;
    ra_read_data = '0;
    clear_ctl();
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 0);
    check("reset_retired", retired, 0);
    check("reset_halted", halted, 0);
    check("reset_issue", issue, 0);
    check("reset_jal_out", jal_out, 0);
    check("reset_ra_write_data", ra_write_data, 0);
    reset = 1'b0;
    check("fetch_req_after_reset", fetch_req, 1);

    for (int i = 0; i < 9; i++)
      run_instr(K_SEQ, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 2), $urandom_range(0, 2));
    check("retired_after_9", retired, 9);
    check("pc_after_wrap", pc, 1);

    run_instr(K_BR, 7, 3'b110, 5, 0, 0);
    check("branch_minus2", pc, 0);
    run_instr(K_SEQ, 7, 1, 5, 0, 1);
    run_instr(K_SEQ, 7, 1, 5, 1, 0);
    run_instr(K_JAL, 5, 2, 1, 0, 0);
    check("jal_target", pc, 5);
    check("jal_ra_held", ra_write_data, 3);
    run_instr(K_JR, 1, 2, 3, 0, 0);
    check("jr_target", pc, 3);
    run_instr(K_SEQ, 0, 0, 0, 0, 0);
    run_instr(K_JALJR, 1, 0, 6, 0, 0);
    check("jal_jr_target", pc, 6);
    check("jal_jr_ra_unchanged", ra_write_data, 3);
    run_instr(K_BR, 0, 3, 0, 0, 0);
    check("branch_plus3_wrap", pc, 2);
    run_instr(K_JAL, 3, 0, 0, 0, 0);
    check("pc_before_halt", pc, 3);

    // Halt carries a jal as well: halt must win and leave $ra3 alone.
    fetch_phase(1, 1);
    ctl_valid  = 1'b1;
    ctl_halt   = 1'b1;
    ctl_jal    = 1'b1;
    ctl_target = 3'd6;
    if (m_ret < 255) m_ret++;
    @(posedge clk); #1;
    clear_ctl();
    check("halted_set", halted, 1);
    check("halt_pc", pc, 3);
    check("halt_retired", retired, m_ret);
    check("halt_fetch_req", fetch_req, 0);
    for (int i = 0; i < 12; i++) begin
      fetch_ack  = 1'($urandom);
      ctl_valid  = 1'($urandom);
      ctl_jal    = 1'($urandom);
      ctl_jr     = 1'($urandom);
      ctl_branch = 1'($urandom);
      ctl_halt   = 1'($urandom);
      ctl_target = ADDR_W'($urandom);
      @(posedge clk); #1;
    end
    fetch_ack = 1'b0;
    clear_ctl();
    check("halt_frozen_pc", pc, 3);
    check("halt_frozen_retired", retired, m_ret);
    check("halt_frozen_halted", halted, 1);
    check("halt_frozen_fetch_req", fetch_req, 0);

    #2 reset = 1'b1;
    #1;
    check("async_reset_pc", pc, 0);
    check("async_reset_halted", halted, 0);
    check("async_reset_retired", retired, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    check("fetch_req_after_halt_reset", fetch_req, 1);

    run_random(270);
    check("retired_saturated", retired, 255);

    // Reset landing while a jal is being resolved must suppress the strobe.
    fetch_phase(0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    ctl_valid  = 1'b1;
    ctl_jal    = 1'b1;
    ctl_target = 3'd5;
    reset      = 1'b1;
    #1;
    check("exec_reset_pc", pc, 0);
    check("exec_reset_jal_out", jal_out, 0);
    model_reset();
    @(posedge clk); #1;
    check("exec_reset_jal_out_later", jal_out, 0);
    clear_ctl();
    reset = 1'b0;
    @(posedge clk); #1;
    check("fetch_req_after_exec_reset", fetch_req, 1);

    check("fetch_q_drained", fetch_q.size(), 0);
    check("issue_q_drained", issue_q.size(), 0);
    check("jal_q_drained", jal_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
